// File: rtl/t08_memory_handler.sv
// t08_memory_handler: data-memory access sequencer for the team 08 RV32I core.
// It runs one byte/half/word load or store on a word-addressed req/ack bus.
// It stalls the core with freeze while the access is in flight.
// Load results are returned sign- or zero-extended.
// Optional feature macro: T08_MEMH_TIMEOUT_EN enables a watchdog.
// The watchdog abandons an unacknowledged access after TIMEOUT_CYCLES cycles and flags err.
module t08_memory_handler #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    output logic [31:0] load_data,
    output logic        freeze,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        cmd;
    logic        fault_in;
    logic        timeout;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    // Misalignment and illegal funct3 detection, evaluated on the live command.
    function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] o);
        logic bad;
        if (is_store) bad = (f3 >= 3'b011);
        else          bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        case (f3[1:0])
            2'b01:   if (o[0])        bad = 1'b1;
            2'b10:   if (o != 2'b00)  bad = 1'b1;
            default: ;
        endcase
        return bad;
    endfunction

    // Byte-lane enables for the access width at byte offset o.
    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] o);
        case (f3[1:0])
            2'b00:   return 4'b0001 << o;
            2'b01:   return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the lane enables alone pick the target.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it per funct3.
    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] o,
                                                 input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = rd[{o, 3'b000} +: 8];
        h = rd[{o[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign cmd      = read | write;
    assign fault_in = access_fault(write, funct3, addr[1:0]);
    assign freeze   = (state == S_ACCESS) | ((state == S_IDLE) & cmd);

`ifdef T08_MEMH_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;

    // Watchdog: cleared when an access starts, counts every unacknowledged ACCESS cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)                                      to_cnt <= '0;
        else if (state == S_IDLE && cmd && !fault_in)   to_cnt <= '0;
        else if (state == S_ACCESS && !mem_ack)         to_cnt <= to_cnt + 16'd1;
    end

    // The last permitted ACCESS cycle is the one where the counter shows TIMEOUT_CYCLES-1.
    assign timeout = (state == S_ACCESS) && !mem_ack && (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; store wins over load because only write is tested for the kind.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd) state_nxt = fault_in ? S_DONE : S_ACCESS;
            S_ACCESS: if (mem_ack || timeout) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered bus request, load capture and done/err pulses.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            load_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd) begin
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        if (fault_in) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            mem_read  <= ~write;
                            mem_write <= write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_sel   <= lane_sel(funct3, addr[1:0]);
                            mem_wdata <= lane_wdata(funct3, store_data);
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        if (mem_read) load_data <= extract_load(f3_q, off_q, mem_rdata);
                    end else if (timeout) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t08_memory_handler.sv
// tb_t08_memory_handler: directed self-checking bench for t08_memory_handler.
// Macro T08_MEMH_TIMEOUT_EN selects the watchdog scenario when it is defined.
`timescale 1ns/1ps
module tb_t08_memory_handler;

    logic        clk;
    logic        nRst;
    logic        read, write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] load_data;
    logic        freeze, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by txn.
    int          r_done_cyc;
    logic        r_err, r_any_req, r_rd, r_wr, r_req_at_done;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_sel;
    logic [15:0] r_frz;
    logic        seen_done;

    t08_memory_handler #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .read       (read),
        .write      (write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_sel    (mem_sel),
        .load_data  (load_data),
        .freeze     (freeze),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit, got running, want finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One command: cycle 0 is the accept cycle, ack is driven in cycle ack_at (-1 = never).
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int ack_at, input int max_cyc);
        logic got;
        got = 1'b0;
        r_done_cyc = -1; r_err = 1'b0; r_any_req = 1'b0; r_rd = 1'b0; r_wr = 1'b0;
        r_addr = '0; r_wdata = '0; r_sel = '0; r_frz = '0; r_req_at_done = 1'b0;
        @(posedge clk); #1;
        read = rd; write = wr; funct3 = f3; addr = a; store_data = sd;
        mem_ack = 1'b0; mem_rdata = 32'hA5A5A5A5;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                read = 1'b0; write = 1'b0;
                mem_ack   = (c == ack_at);
                mem_rdata = (c == ack_at) ? rdata : 32'hA5A5A5A5;
            end
            @(negedge clk);
            if (c < 16) r_frz[c] = freeze;
            if ((mem_read || mem_write) && !got) begin
                got = 1'b1; r_any_req = 1'b1; r_rd = mem_read; r_wr = mem_write;
                r_addr = mem_addr; r_wdata = mem_wdata; r_sel = mem_sel;
            end
            if (done) begin
                r_done_cyc = c; r_err = err; r_req_at_done = mem_read | mem_write;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        nRst = 1'b0; read = 1'b0; write = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("rst_ctrl", {27'd0, mem_read, mem_write, done, err, freeze}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_sel", {28'd0, mem_sel}, 32'd0);
        check("rst_load", load_data, 32'd0);
        read = 1'b1; #1;
        check("rst_freeze_cmd", {31'd0, freeze}, 32'd1);
        read = 1'b0;
        @(negedge clk); nRst = 1'b1;

        // LB at 0x1003, ack in the second ACCESS cycle.
        txn(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80223344, 2, 20);
        check("lb_lat", 32'(r_done_cyc), 32'd3);
        check("lb_err", {31'd0, r_err}, 32'd0);
        check("lb_req", {30'd0, r_rd, r_wr}, 32'b10);
        check("lb_addr", r_addr, 32'h1000);
        check("lb_sel", {28'd0, r_sel}, 32'h8);
        check("lb_load", load_data, 32'hFFFFFF80);
        check("lb_freeze", {28'd0, r_frz[3:0]}, 32'b0111);

        // LHU at 0x2002, fastest ack; issued back-to-back after the previous DONE.
        txn(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h80011234, 1, 20);
        check("lhu_lat", 32'(r_done_cyc), 32'd2);
        check("lhu_sel", {28'd0, r_sel}, 32'hC);
        check("lhu_load", load_data, 32'h00008001);

        // SB at 0x11.
        txn(1'b0, 1'b1, 3'b000, 32'h11, 32'hDEADBEEF, 32'h0, 1, 20);
        check("sb_req", {30'd0, r_rd, r_wr}, 32'b01);
        check("sb_sel", {28'd0, r_sel}, 32'h2);
        check("sb_wdata", r_wdata, 32'hEFEFEFEF);
        check("sb_addr", r_addr, 32'h10);
        check("sb_load_hold", load_data, 32'h00008001);

        // SW misaligned at 0x6.
        txn(1'b0, 1'b1, 3'b010, 32'h6, 32'h12345678, 32'h0, 1, 20);
        check("sw_mis_req", {31'd0, r_any_req}, 32'd0);
        check("sw_mis_lat", 32'(r_done_cyc), 32'd1);
        check("sw_mis_err", {31'd0, r_err}, 32'd1);
        check("sw_mis_load", load_data, 32'h00008001);

        // LH misaligned at 0x3.
        txn(1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 32'hFFFFFFFF, 1, 20);
        check("lh_mis_req", {31'd0, r_any_req}, 32'd0);
        check("lh_mis_lat", 32'(r_done_cyc), 32'd1);
        check("lh_mis_err", {31'd0, r_err}, 32'd1);
        check("lh_mis_load", load_data, 32'h00008001);

        // LW with a slow ack.
        txn(1'b1, 1'b0, 3'b010, 32'h3004, 32'h0, 32'h12345678, 3, 20);
        check("lw_lat", 32'(r_done_cyc), 32'd4);
        check("lw_sel_addr", {r_addr[27:0], r_sel}, {28'h0003004, 4'hF});
        check("lw_load", load_data, 32'h12345678);

        // LBU at byte 1.
        txn(1'b1, 1'b0, 3'b100, 32'h5001, 32'h0, 32'h00009A00, 1, 20);
        check("lbu_sel", {28'd0, r_sel}, 32'h2);
        check("lbu_load", load_data, 32'h0000009A);

        // LH, low half, negative.
        txn(1'b1, 1'b0, 3'b001, 32'h6000, 32'h0, 32'h0000F00D, 1, 20);
        check("lh_sel", {28'd0, r_sel}, 32'h3);
        check("lh_load", load_data, 32'hFFFFF00D);

        // SH, upper half.
        txn(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 1, 20);
        check("sh_sel", {28'd0, r_sel}, 32'hC);
        check("sh_wdata", r_wdata, 32'hABCDABCD);
        check("sh_addr", r_addr, 32'h20);
        check("sh_load_hold", load_data, 32'hFFFFF00D);

        // Illegal load and store encodings.
        txn(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 20);
        check("ld_f3_fault", {30'd0, r_any_req, r_err}, 32'b01);
        check("ld_f3_load", load_data, 32'hFFFFF00D);
        txn(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 20);
        check("st_f3_fault", {30'd0, r_any_req, r_err}, 32'b01);

        // An ack while idle does nothing.
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h0;
        @(negedge clk);
        check("idle_ack", {29'd0, mem_read, done, err}, 32'd0);
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_hold", load_data, 32'hFFFFF00D);

        // Reset in the middle of an ACCESS.
        @(posedge clk); #1; read = 1'b1; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1; read = 1'b0;
        @(negedge clk);
        check("mid_req", {31'd0, mem_read}, 32'd1);
        #2 nRst = 1'b0; #1;
        check("mid_rst_ctrl", {27'd0, mem_read, mem_write, done, err, freeze}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_load", load_data, 32'd0);
        @(negedge clk); nRst = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("mid_rst_nodone", {31'd0, seen_done}, 32'd0);

        // read and write both high: performs the write.
        txn(1'b1, 1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 32'h11111111, 1, 20);
        check("rw_req", {30'd0, r_rd, r_wr}, 32'b01);
        check("rw_wdata", r_wdata, 32'hCAFEF00D);
        check("rw_sel_lat", {r_sel, 28'(r_done_cyc)}, {4'hF, 28'd2});
        check("rw_load", load_data, 32'd0);

`ifdef T08_MEMH_TIMEOUT_EN
        // Never ack: watchdog ends the access after four ACCESS cycles.
        txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, -1, 40);
        check("to_lat", 32'(r_done_cyc), 32'd5);
        check("to_err", {31'd0, r_err}, 32'd1);
        check("to_drop", {31'd0, r_req_at_done}, 32'd0);
        check("to_load", load_data, 32'd0);
`else
        // Never ack: the request is still up 1000 cycles later.
        txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, -1, 1000);
        check("noto_nodone", 32'(r_done_cyc), 32'hFFFFFFFF);
        check("noto_req", {31'd0, mem_read}, 32'd1);
        nRst = 1'b0; #1;
        check("noto_rst", {31'd0, mem_read}, 32'd0);
        @(negedge clk); nRst = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/t08_memory_handler.md
# t08_memory_handler

Multi-cycle data-memory access sequencer for the team 08 RV32I core. It consumes the `read`/`write`/`funct3` command issued by the control unit, the ALU-computed address and the rs2 store value, and runs one byte/half/word transaction on a word-addressed req/ack memory bus. It stalls the core with `freeze` while the transaction is in flight. It returns sign- or zero-extended load data to the register-file write mux.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles. Used only when `T08_MEMH_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: system clock. One clock domain; everything is rising-edge.
- `nRst` input 1: reset. Asynchronous, active-low.
- `read` input 1: load command from the control unit.
- `write` input 1: store command from the control unit.
- `funct3` input 3: access width and signedness (RV32I encoding).
- `addr` input 32: byte address from the ALU.
- `store_data` input 32: rs2 value.
- `mem_ack` input 1: bus completion strobe.
- `mem_rdata` input 32: bus read word. Valid when `mem_ack` is high.
- `mem_read` output 1: bus read request.
- `mem_write` output 1: bus write request.
- `mem_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_sel` output 4: byte-lane enables.
- `load_data` output 32: extended load result.
- `freeze` output 1: stall to the PC and register file.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle fault pulse, coincident with `done`.

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- **IDLE**
  - If `write` is high, accept a store. `write` has priority if `read` and `write` are both high.
  - Else if `read` is high, accept a load.
  - On accept, latch `addr`, `funct3` and `store_data`, then run the fault check.
  - No fault: go to ACCESS.
  - Fault: go to DONE with a fault flag set. No bus activity occurs.
- **Faults**
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - Load `funct3` ∈ {011, 110, 111}.
  - Store `funct3` ≥ 011.
- **ACCESS**
  - `mem_read` or `mem_write` is held high, and `mem_addr`/`mem_sel`/`mem_wdata` are held stable, until `mem_ack` is sampled high.
  - On ack: capture the extended load into `load_data` (loads only), then go to DONE.
- **DONE**
  - `done` = 1 for one cycle; `err` = fault flag.
  - Next state is IDLE unconditionally. The core retires the memory instruction on this edge.
- **Lane mapping**, with `o` = `addr[1:0]`:
  - Byte: `mem_sel` = `4'b0001<<o`; `mem_wdata` = `{4{store_data[7:0]}}`.
  - Half: `mem_sel` = `o[1] ? 4'b1100 : 4'b0011`; `mem_wdata` = `{2{store_data[15:0]}}`.
  - Word: `mem_sel` = `4'b1111`; `mem_wdata` = `store_data`.
- **Load extraction**: select the byte at `mem_rdata[8*o +: 8]` or the half at `mem_rdata[16*o[1] +: 16]`.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- **Output hold rules**
  - `load_data` holds its value until the next successful load. Stores and faults do not modify it.
  - A faulted load leaves `load_data` unchanged.
- **`freeze`** is combinational: `(state==ACCESS) | (state==IDLE & (read|write))`. It is low in DONE.

## Timing
- Reset value of every output is 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `mem_sel`, `load_data`, `done`, `err`. `freeze` is 0 unless `read`/`write` is high in IDLE.
- Bus outputs are registered. A request appears the cycle after accept.
- Latency, with accept at cycle 0:
  - Fastest case: ack in cycle 1 gives `done` in cycle 2.
  - General case: ack in cycle k gives `done` in cycle k+1.
  - Fault: `done`+`err` in cycle 1.
- Back-to-back commands: a command present in the cycle after DONE is accepted normally. The handler does not need a gap cycle.
- `mem_ack` outside ACCESS is ignored.
- `read`/`write` changes during ACCESS are ignored, because the command is latched at accept.
- `nRst` low at any time, including mid-ACCESS:
  - State goes to IDLE immediately.
  - Requests drop asynchronously.
  - The in-flight transaction is abandoned and no `done` pulse is produced.

## Configuration
- `T08_MEMH_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, drop the request and go to DONE with `err` = 1. `load_data` is unchanged.
- Not defined:
  - The counter and parameter are unused.
  - ACCESS waits for `mem_ack` indefinitely.

## Test plan
- LB, `addr`=0x1003, `mem_rdata`=0x80_22_33_44, ack in the second ACCESS cycle:
  - `mem_sel`=1000, `mem_addr`=0x1000.
  - `load_data`=0xFFFFFF80.
  - `done` in cycle 3; `freeze` high in cycles 0–2.
- LHU, `addr`=0x2002, `mem_rdata`=0x8001_1234: `load_data`=0x00008001, `mem_sel`=1100.
- SB, `addr`=0x11, `store_data`=0xDEADBEEF: `mem_write`=1, `mem_sel`=0010, `mem_wdata`=0xEFEFEFEF, `mem_addr`=0x10.
- SW at `addr`=0x6 and LH at `addr`=0x3:
  - No `mem_read`/`mem_write` ever.
  - `done`=`err`=1 in cycle 1.
  - `load_data` unchanged.
- `nRst` pulsed low during ACCESS: all outputs go to 0 immediately, and no `done` follows.
  - Then a fresh LW with `read` and `write` both high performs a write.
- With `T08_MEMH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, never ack:
  - `err`+`done` fire after 4 ACCESS cycles.
  - The request drops.
  - Without the macro, the request is still high after 1000 cycles.
